store_buffer_be: RTL and testbench
==================================

Name: store_buffer_be

Overview:
- Parametrised next-generation store buffer for the data-memory stage, sitting between the execute-side store/load ports and the data cache write port.
- Buffers byte-masked stores (byte/half/word) in a circular FIFO and coalesces a store into the youngest entry when both target the same word.
- Forwards load data per byte, youngest-wins, and drains entries to the cache through a valid/ready handshake.
- Adds byte enables, coalescing, partial-hit detection and explicit drain, none of which the previous store buffer has.

Parameters:
- N_LINES, 4, number of buffer entries (power of two, >=2).
- REG_WIDTH, 32, data word width in bits (multiple of 8).
- VA_WIDTH, 32, address width.
- N_BYTES (localparam), REG_WIDTH/8, byte lanes per word.
- OFF_WIDTH (localparam), $clog2(N_BYTES), byte-offset bits.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- i_is_store  in  1  store request this cycle.
- i_st_addr  in  VA_WIDTH  store byte address.
- i_st_size  in  2  0=byte, 1=half, 2=word, 3=reserved.
- i_st_data  in  REG_WIDTH  store data, right-aligned.
- i_is_load  in  1  load lookup this cycle.
- i_ld_addr  in  VA_WIDTH  load byte address.
- i_ld_size  in  2  same encoding as i_st_size.
- i_drain  in  1  empty the buffer; blocks new stores while high.
- o_fwd_hit  out  1  all requested load bytes found in the buffer.
- o_fwd_partial  out  1  some, but not all, requested bytes found.
- o_fwd_data  out  REG_WIDTH  word-lane forwarded data; uncovered lanes are 0.
- o_misaligned  out  1  store or load is misaligned or uses size 3.
- o_stall  out  1  store not accepted, or load partial.
- o_full  out  1  count == N_LINES.
- o_empty  out  1  count == 0.
- o_commit_valid  out  1  head entry presented to the cache.
- o_commit_addr  out  VA_WIDTH  head word address; low OFF_WIDTH bits are 0.
- o_commit_data  out  REG_WIDTH  head word data, lane-placed.
- o_commit_be  out  N_BYTES  head byte enables.
- i_commit_ready  in  1  cache accepts the head this cycle.

Behaviour:
- Reset:
  - head, tail and count are cleared; all entries are invalid.
  - Next cycle: o_commit_valid=0, o_empty=1, o_full=0. o_fwd_hit, o_fwd_partial and o_stall are 0 unless a current input asserts them combinationally.
  - Reset mid-operation discards all buffered stores without committing them.
- Entry layout: valid, word address (addr with the low OFF_WIDTH bits cleared), data[REG_WIDTH], be[N_BYTES].
- Store lane placement: mask is 1, 3 or 0xF… for sizes 0/1/2, shifted left by addr[OFF_WIDTH-1:0]; data is shifted left by 8*offset.
- Alignment: a half at an odd address, a word at a non-zero offset, or size 3 is misaligned.
  - A misaligned store asserts o_misaligned the same cycle and is dropped; no state change.
  - A misaligned load asserts o_misaligned and forces o_fwd_hit=0 and o_fwd_partial=0.
- Store acceptance, evaluated combinationally; the state update happens at the clock edge.
  - Coalesce: if count>=2 and the youngest entry (tail-1) has the same word address, merge into it. Masked bytes are overwritten, be |= mask, count is unchanged. The head entry is never coalesced into, even when count==1.
  - Enqueue: otherwise, if !full and !i_drain, write the entry at tail, then tail+1 (mod N_LINES) and count+1.
  - Stall: otherwise (full, or i_drain high) o_stall=1 and the store is not accepted; the producer holds and retries. A commit pop in the same cycle does not un-stall a full buffer; acceptance happens the next cycle.
- Commit:
  - o_commit_valid = !empty; outputs always reflect the head entry.
  - On valid && ready, head+1 and count-1.
  - Outputs are stable while valid && !ready.
  - Enqueue and pop in the same cycle leave count unchanged.
- Forwarding (combinational, reads pre-edge contents only; a store issued in the same cycle is not visible):
  - Build the load mask as for stores.
  - For each lane, the youngest valid entry with a matching word address and be[lane]=1 supplies the byte.
  - All mask lanes covered: o_fwd_hit=1.
  - Some lanes covered: o_fwd_partial=1 and o_stall=1, held until the matching entries drain.
  - No lanes covered: both flags 0.
  - A load that matches the head while it commits in the same cycle still gets the pre-edge data.
- Drain: while i_drain is high, no store is accepted; commits continue. The requester waits for o_empty=1.
- Pointers are OFF-free $clog2(N_LINES) bits and wrap modulo N_LINES; count is $clog2(N_LINES)+1 bits.

Test Plan:
- Forward hit: sw 0x100=0xDEADBEEF, ready=0; next cycle lw 0x100 -> o_fwd_hit=1, o_fwd_data=0xDEADBEEF.
- Partial hit: sb 0x201=0xAA; then lw 0x200 -> o_fwd_partial=1, o_stall=1. Raise ready -> commit addr 0x200, be=4'b0010, data=0x0000AA00. Next cycle the load gives hit=0, partial=0, stall=0.
- Coalesce: ready=0; sw 0x400=0x11111111, sw 0x300=0, sb 0x302=0x77 -> count=2, entry 1 data=0x00770000, be=4'b1111. Then sb 0x400 (not youngest) -> count=3.
- Full: ready=0; 4 stores to distinct words -> o_full=1. A 5th store gives o_stall=1 with count stuck at 4. Ready=1 for one cycle -> first store commits; the 5th is accepted the following cycle.
- Misaligned: sh 0x101 -> o_misaligned=1, count unchanged; lw 0x102 -> o_misaligned=1, o_fwd_hit=0.
- Reset and drain: with count=3, pulse rst -> next cycle o_empty=1, o_commit_valid=0. Then i_drain=1 with a store -> o_stall=1, store not accepted.

Source files
------------

// File: rtl/store_buffer_be.sv
// store_buffer_be: byte-masked store buffer for the data-memory stage.
// Circular FIFO of word-addressed entries. A store can merge into the
// youngest entry, loads are forwarded per byte lane with the youngest
// entry winning, and the head entry drains to the cache via valid/ready.
module store_buffer_be #(
    parameter int N_LINES   = 4,
    parameter int REG_WIDTH = 32,
    parameter int VA_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_is_store,
    input  logic [VA_WIDTH-1:0]          i_st_addr,
    input  logic [1:0]                   i_st_size,
    input  logic [REG_WIDTH-1:0]         i_st_data,
    input  logic                         i_is_load,
    input  logic [VA_WIDTH-1:0]          i_ld_addr,
    input  logic [1:0]                   i_ld_size,
    input  logic                         i_drain,
    output logic                         o_fwd_hit,
    output logic                         o_fwd_partial,
    output logic [REG_WIDTH-1:0]         o_fwd_data,
    output logic                         o_misaligned,
    output logic                         o_stall,
    output logic                         o_full,
    output logic                         o_empty,
    output logic                         o_commit_valid,
    output logic [VA_WIDTH-1:0]          o_commit_addr,
    output logic [REG_WIDTH-1:0]         o_commit_data,
    output logic [(REG_WIDTH/8)-1:0]     o_commit_be,
    input  logic                         i_commit_ready
);
    localparam int N_BYTES   = REG_WIDTH / 8;
    localparam int OFF_WIDTH = $clog2(N_BYTES);
    localparam int PW        = $clog2(N_LINES);
    localparam int CW        = PW + 1;

    // Byte-lane mask for a size code, placed at the given byte offset.
    function automatic logic [N_BYTES-1:0] lane_mask(input logic [1:0] sz,
                                                     input logic [OFF_WIDTH-1:0] off);
        logic [N_BYTES-1:0] base;
        case (sz)
            2'd0:    base = N_BYTES'(1);
            2'd1:    base = N_BYTES'(3);
            default: base = '1;
        endcase
        return base << off;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz,
                                           input logic [OFF_WIDTH-1:0] off);
        return (sz == 2'd3) || ((sz == 2'd1) && off[0]) || ((sz == 2'd2) && (off != '0));
    endfunction

    logic [VA_WIDTH-1:0]  r_addr  [N_LINES];
    logic [REG_WIDTH-1:0] r_data  [N_LINES];
    logic [N_BYTES-1:0]   r_be    [N_LINES];
    logic [N_LINES-1:0]   r_valid;
    logic [PW-1:0]        r_head;
    logic [PW-1:0]        r_tail;
    logic [CW-1:0]        r_count;

    logic                 w_full, w_empty;
    logic [OFF_WIDTH-1:0] w_st_off, w_ld_off;
    logic [VA_WIDTH-1:0]  w_st_word, w_ld_word;
    logic [N_BYTES-1:0]   w_st_mask, w_ld_mask;
    logic [REG_WIDTH-1:0] w_st_wdata, w_st_bitmask;
    logic                 w_st_mis, w_ld_mis;
    logic                 w_st_ok, w_coalesce, w_push, w_pop, w_st_stall;
    logic [PW-1:0]        w_youngest;
    logic [N_BYTES-1:0]   w_cov, w_ld_cov;
    logic [REG_WIDTH-1:0] w_fwd_raw;
    logic                 w_ld_ok, w_ld_partial;

    // Store/load decode: word address, lane mask, lane-placed data, alignment.
    always_comb begin
        w_st_off     = i_st_addr[OFF_WIDTH-1:0];
        w_ld_off     = i_ld_addr[OFF_WIDTH-1:0];
        w_st_word    = {i_st_addr[VA_WIDTH-1:OFF_WIDTH], {OFF_WIDTH{1'b0}}};
        w_ld_word    = {i_ld_addr[VA_WIDTH-1:OFF_WIDTH], {OFF_WIDTH{1'b0}}};
        w_st_mask    = lane_mask(i_st_size, w_st_off);
        w_ld_mask    = lane_mask(i_ld_size, w_ld_off);
        w_st_wdata   = i_st_data << {w_st_off, 3'b000};
        w_st_mis     = is_misaligned(i_st_size, w_st_off);
        w_ld_mis     = is_misaligned(i_ld_size, w_ld_off);
        w_st_bitmask = '0;
        for (int unsigned b = 0; b < N_BYTES; b++)
            w_st_bitmask[8*b +: 8] = {8{w_st_mask[b]}};
    end

    // Store acceptance: coalesce into youngest (never the head), else enqueue, else stall.
    always_comb begin
        w_full     = (r_count == CW'(N_LINES));
        w_empty    = (r_count == '0);
        w_youngest = r_tail - PW'(1);
        w_st_ok    = i_is_store && !w_st_mis;
        w_coalesce = w_st_ok && !i_drain && (r_count >= CW'(2)) &&
                     (r_addr[w_youngest] == w_st_word);
        w_push     = w_st_ok && !w_coalesce && !w_full && !i_drain;
        w_st_stall = w_st_ok && !w_coalesce && !w_push;
        w_pop      = !w_empty && i_commit_ready;
    end

    // Per-lane forwarding: walk entries oldest to youngest so younger bytes overwrite.
    always_comb begin
        logic [PW-1:0] idx;
        idx       = '0;
        w_cov     = '0;
        w_fwd_raw = '0;
        for (int unsigned k = 0; k < N_LINES; k++) begin
            idx = r_head + PW'(k);
            if (r_valid[idx] && (r_addr[idx] == w_ld_word)) begin
                for (int unsigned b = 0; b < N_BYTES; b++) begin
                    if (r_be[idx][b]) begin
                        w_cov[b]           = 1'b1;
                        w_fwd_raw[8*b +: 8] = r_data[idx][8*b +: 8];
                    end
                end
            end
        end
        w_ld_ok      = i_is_load && !w_ld_mis;
        w_ld_cov     = w_cov & w_ld_mask;
        w_ld_partial = w_ld_ok && (w_ld_cov != '0) && (w_ld_cov != w_ld_mask);
        o_fwd_hit    = w_ld_ok && (w_ld_cov == w_ld_mask);
        o_fwd_partial = w_ld_partial;
        o_fwd_data   = '0;
        if (w_ld_ok) begin
            for (int unsigned b = 0; b < N_BYTES; b++)
                if (w_ld_cov[b]) o_fwd_data[8*b +: 8] = w_fwd_raw[8*b +: 8];
        end
    end

    // Status and commit-port outputs, always reflecting the head entry.
    always_comb begin
        o_misaligned   = (i_is_store && w_st_mis) || (i_is_load && w_ld_mis);
        o_stall        = w_st_stall || w_ld_partial;
        o_full         = w_full;
        o_empty        = w_empty;
        o_commit_valid = !w_empty;
        o_commit_addr  = r_addr[r_head];
        o_commit_data  = r_data[r_head];
        o_commit_be    = r_be[r_head];
    end

    // Buffer state update: pop at head, push at tail, or merge into youngest.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            for (int unsigned i = 0; i < N_LINES; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
                r_be[i]   <= '0;
            end
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PW'(1);
            end
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_addr[r_tail]  <= w_st_word;
                r_data[r_tail]  <= w_st_wdata;
                r_be[r_tail]    <= w_st_mask;
                r_tail          <= r_tail + PW'(1);
            end
            if (w_coalesce) begin
                r_data[w_youngest] <= (r_data[w_youngest] & ~w_st_bitmask) |
                                      (w_st_wdata & w_st_bitmask);
                r_be[w_youngest]   <= r_be[w_youngest] | w_st_mask;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: tb/tb_store_buffer_be.sv
// tb_store_buffer_be: directed-vector bench for store_buffer_be with
// hand-computed expectations for forwarding, coalescing, full, drain and reset.
module tb_store_buffer_be;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_is_store;
    logic [31:0] i_st_addr;
    logic [1:0]  i_st_size;
    logic [31:0] i_st_data;
    logic        i_is_load;
    logic [31:0] i_ld_addr;
    logic [1:0]  i_ld_size;
    logic        i_drain;
    logic        o_fwd_hit, o_fwd_partial;
    logic [31:0] o_fwd_data;
    logic        o_misaligned, o_stall, o_full, o_empty;
    logic        o_commit_valid;
    logic [31:0] o_commit_addr, o_commit_data;
    logic [3:0]  o_commit_be;
    logic        i_commit_ready;

    int n_tests = 0;
    int n_fail  = 0;

    store_buffer_be #(.N_LINES(4), .REG_WIDTH(32), .VA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .i_is_store(i_is_store), .i_st_addr(i_st_addr), .i_st_size(i_st_size),
        .i_st_data(i_st_data),
        .i_is_load(i_is_load), .i_ld_addr(i_ld_addr), .i_ld_size(i_ld_size),
        .i_drain(i_drain),
        .o_fwd_hit(o_fwd_hit), .o_fwd_partial(o_fwd_partial), .o_fwd_data(o_fwd_data),
        .o_misaligned(o_misaligned), .o_stall(o_stall), .o_full(o_full), .o_empty(o_empty),
        .o_commit_valid(o_commit_valid), .o_commit_addr(o_commit_addr),
        .o_commit_data(o_commit_data), .o_commit_be(o_commit_be),
        .i_commit_ready(i_commit_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_is_store = 1'b0; i_st_addr = '0; i_st_size = 2'd0; i_st_data = '0;
        i_is_load  = 1'b0; i_ld_addr = '0; i_ld_size = 2'd0;
        i_drain    = 1'b0;
    endtask

    task automatic st(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        i_is_store = 1'b1; i_st_addr = a; i_st_size = sz; i_st_data = d;
    endtask

    task automatic ld(input logic [31:0] a, input logic [1:0] sz);
        i_is_load = 1'b1; i_ld_addr = a; i_ld_size = sz;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] be);
        check({tag, "_valid"}, 64'(o_commit_valid), 64'd1);
        check({tag, "_addr"},  64'(o_commit_addr), 64'(a));
        check({tag, "_data"},  64'(o_commit_data), 64'(d));
        check({tag, "_be"},    64'(o_commit_be),   64'(be));
    endtask

    initial begin
        idle();
        i_commit_ready = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        // Reset state
        check("rst_empty", 64'(o_empty), 64'd1);
        check("rst_full", 64'(o_full), 64'd0);
        check("rst_cvalid", 64'(o_commit_valid), 64'd0);
        check("rst_hit", 64'(o_fwd_hit), 64'd0);
        check("rst_partial", 64'(o_fwd_partial), 64'd0);
        check("rst_stall", 64'(o_stall), 64'd0);

        // Forward hit
        st(32'h100, 2'd2, 32'hDEADBEEF); #1;
        check("fh_st_stall", 64'(o_stall), 64'd0);
        tick(); idle();
        ld(32'h100, 2'd2); #1;
        check("fh_hit", 64'(o_fwd_hit), 64'd1);
        check("fh_partial", 64'(o_fwd_partial), 64'd0);
        check("fh_data", 64'(o_fwd_data), 64'hDEADBEEF);
        idle();
        expect_head("fh_head", 32'h100, 32'hDEADBEEF, 4'hF);
        i_commit_ready = 1'b1; tick(); i_commit_ready = 1'b0; #1;
        check("fh_empty", 64'(o_empty), 64'd1);

        // Partial hit
        st(32'h201, 2'd0, 32'h000000AA); tick(); idle();
        ld(32'h200, 2'd2); #1;
        check("ph_partial", 64'(o_fwd_partial), 64'd1);
        check("ph_stall", 64'(o_stall), 64'd1);
        check("ph_hit", 64'(o_fwd_hit), 64'd0);
        check("ph_data", 64'(o_fwd_data), 64'h0000AA00);
        expect_head("ph_head", 32'h200, 32'h0000AA00, 4'b0010);
        i_commit_ready = 1'b1; #1;
        check("ph_pre_edge_partial", 64'(o_fwd_partial), 64'd1);
        tick(); i_commit_ready = 1'b0; #1;
        check("ph_after_hit", 64'(o_fwd_hit), 64'd0);
        check("ph_after_partial", 64'(o_fwd_partial), 64'd0);
        check("ph_after_stall", 64'(o_stall), 64'd0);
        idle();

        // Coalesce into youngest entry
        st(32'h400, 2'd2, 32'h11111111); tick();
        st(32'h300, 2'd2, 32'h00000000); tick();
        st(32'h302, 2'd0, 32'h00000077); #1;
        check("co_stall", 64'(o_stall), 64'd0);
        tick();
        st(32'h400, 2'd0, 32'h00000022); tick(); idle();
        ld(32'h400, 2'd2); #1;
        check("co_fwd_hit", 64'(o_fwd_hit), 64'd1);
        check("co_fwd_data", 64'(o_fwd_data), 64'h11111122);
        idle();
        i_commit_ready = 1'b1; #1;
        expect_head("co_e0", 32'h400, 32'h11111111, 4'hF); tick();
        expect_head("co_e1", 32'h300, 32'h00770000, 4'hF); tick();
        expect_head("co_e2", 32'h400, 32'h00000022, 4'h1); tick();
        i_commit_ready = 1'b0; #1;
        check("co_empty", 64'(o_empty), 64'd1);

        // Full and stall
        for (int i = 0; i < 4; i++) begin
            st(32'h500 + 32'(4*i), 2'd2, 32'hA0 + 32'(i)); tick();
        end
        idle(); #1;
        check("fu_full", 64'(o_full), 64'd1);
        st(32'h510, 2'd2, 32'h55); #1;
        check("fu_stall", 64'(o_stall), 64'd1);
        tick();
        check("fu_still_full", 64'(o_full), 64'd1);
        check("fu_still_stall", 64'(o_stall), 64'd1);
        i_commit_ready = 1'b1; #1;
        check("fu_pop_stall", 64'(o_stall), 64'd1);
        expect_head("fu_h0", 32'h500, 32'hA0, 4'hF);
        tick(); i_commit_ready = 1'b0; #1;
        check("fu_accept_stall", 64'(o_stall), 64'd0);
        check("fu_notfull", 64'(o_full), 64'd0);
        tick(); idle(); #1;
        check("fu_refull", 64'(o_full), 64'd1);
        i_commit_ready = 1'b1; #1;
        expect_head("fu_h1", 32'h504, 32'hA1, 4'hF); tick();
        expect_head("fu_h2", 32'h508, 32'hA2, 4'hF); tick();
        expect_head("fu_h3", 32'h50C, 32'hA3, 4'hF); tick();
        expect_head("fu_h4", 32'h510, 32'h55, 4'hF); tick();
        i_commit_ready = 1'b0; #1;
        check("fu_empty", 64'(o_empty), 64'd1);

        // Misaligned store and load
        st(32'h100, 2'd2, 32'hDEADBEEF); tick();
        st(32'h101, 2'd1, 32'h0000BEEF); #1;
        check("mis_st", 64'(o_misaligned), 64'd1);
        check("mis_st_stall", 64'(o_stall), 64'd0);
        tick(); idle();
        ld(32'h102, 2'd2); #1;
        check("mis_ld", 64'(o_misaligned), 64'd1);
        check("mis_ld_hit", 64'(o_fwd_hit), 64'd0);
        check("mis_ld_partial", 64'(o_fwd_partial), 64'd0);
        ld(32'h102, 2'd1); #1;
        check("mis_lh_ok", 64'(o_misaligned), 64'd0);
        check("mis_lh_hit", 64'(o_fwd_hit), 64'd1);
        check("mis_lh_data", 64'(o_fwd_data), 64'hDEAD0000);
        idle();
        expect_head("mis_head", 32'h100, 32'hDEADBEEF, 4'hF);
        i_commit_ready = 1'b1; tick(); i_commit_ready = 1'b0; #1;
        check("mis_empty", 64'(o_empty), 64'd1);

        // Reset mid-operation, then drain blocks stores
        for (int i = 0; i < 3; i++) begin
            st(32'h700 + 32'(4*i), 2'd2, 32'(i)); tick();
        end
        idle(); #1;
        check("rd_notempty", 64'(o_empty), 64'd0);
        rst = 1'b1; tick(); rst = 1'b0; #1;
        check("rd_empty", 64'(o_empty), 64'd1);
        check("rd_cvalid", 64'(o_commit_valid), 64'd0);
        check("rd_full", 64'(o_full), 64'd0);
        i_drain = 1'b1;
        st(32'h600, 2'd2, 32'h12345678); #1;
        check("rd_drain_stall", 64'(o_stall), 64'd1);
        tick(); idle(); #1;
        check("rd_drain_empty", 64'(o_empty), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule
